eth_frame_tx: RTL

ETH_FRAME_TX -- requirements
Module: eth_frame_tx

---
 rtl/eth_pkg.sv | 25 ++
 rtl/crc32_byte.sv | 20 ++
 rtl/eth_frame_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, CRC-32 parameters and the transmit FSM state type.
package eth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE        = 8'hD5;
  localparam int unsigned ETH_PREAMBLE_LEN    = 7;
  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  // Bit-reversed form of CRC32_POLY, used by the LSB-first shift register.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_frame_tx.sv
// GMII frame transmitter: preamble/SFD, payload, optional min-length pad, FCS, inter-frame gap.
// Define ETH_FRAME_TX_PAD_EN to build the PAD state and minimum-length counter.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter int unsigned IFG_BYTES       = 12,
  parameter int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [7:0] gmii_txd_o,
  output logic       gmii_tx_en_o,
  output logic       gmii_tx_er_o,
  output logic       busy_o
);

  localparam int unsigned CntMax = (IFG_BYTES > ETH_PREAMBLE_LEN) ? IFG_BYTES : ETH_PREAMBLE_LEN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d, crc_next, fcs_shift;
  logic [7:0]      crc_byte;
  logic [7:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d, tx_er_q, tx_er_d;

`ifdef ETH_FRAME_TX_PAD_EN
  localparam int unsigned LenW = $clog2(MIN_FRAME_BYTES + 1);
  logic [LenW-1:0] len_q, len_d, len_inc;

  assign len_inc = (len_q == LenW'(MIN_FRAME_BYTES)) ? len_q : len_q + 1'b1;
`endif

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_byte),
    .crc_o  (crc_next)
  );

  // FCS goes out as ~CRC, least significant byte first.
  assign fcs_shift = (~crc_q) >> {cnt_q[1:0], 3'b000};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    crc_byte = s_data_i;
    txd_d    = 8'h00;
    tx_en_d  = 1'b0;
    tx_er_d  = 1'b0;
`ifdef ETH_FRAME_TX_PAD_EN
    len_d    = len_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        crc_d = CRC32_INIT;
`ifdef ETH_FRAME_TX_PAD_EN
        len_d = '0;
`endif
        if (s_valid_i) state_d = StPreamble;
      end
      StPreamble: begin
        txd_d   = ETH_PREAMBLE_BYTE;
        tx_en_d = 1'b1;
        if (cnt_q == CntW'(ETH_PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StSfd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSfd: begin
        txd_d   = ETH_SFD_BYTE;
        tx_en_d = 1'b1;
        state_d = StData;
      end
      StData: begin
        tx_en_d = 1'b1;
        cnt_d   = '0;
        if (s_valid_i) begin
          txd_d = s_data_i;
          crc_d = crc_next;
`ifdef ETH_FRAME_TX_PAD_EN
          len_d = len_inc;
`endif
          if (s_last_i) begin
`ifdef ETH_FRAME_TX_PAD_EN
            state_d = (len_inc == LenW'(MIN_FRAME_BYTES)) ? StFcs : StPad;
`else
            state_d = StFcs;
`endif
          end
        end else begin
          // Underrun: abort the frame with a single error byte, no FCS.
          tx_er_d = 1'b1;
          state_d = StIfg;
        end
      end
`ifdef ETH_FRAME_TX_PAD_EN
      StPad: begin
        tx_en_d  = 1'b1;
        crc_byte = 8'h00;
        crc_d    = crc_next;
        len_d    = len_inc;
        if (len_inc == LenW'(MIN_FRAME_BYTES)) state_d = StFcs;
      end
`endif
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_shift[7:0];
        if (cnt_q == CntW'(3)) begin
          cnt_d   = '0;
          state_d = StIfg;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIfg: begin
        crc_d = CRC32_INIT;
`ifdef ETH_FRAME_TX_PAD_EN
        len_d = '0;
`endif
        if (cnt_q == CntW'(IFG_BYTES - 1)) begin
          cnt_d   = '0;
          // Skip the IDLE cycle when a frame is waiting, so the gap is exactly IFG_BYTES.
          state_d = s_valid_i ? StPreamble : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      crc_q   <= '0;
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
`ifdef ETH_FRAME_TX_PAD_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
`ifdef ETH_FRAME_TX_PAD_EN
      len_q   <= len_d;
`endif
    end
  end

  assign s_ready_o    = (state_q == StData);
  assign busy_o       = (state_q != StIdle);
  assign gmii_txd_o   = txd_q;
  assign gmii_tx_en_o = tx_en_q;
  assign gmii_tx_er_o = tx_er_q;

endmodule
